// File: rtl/instr_loader_pkg.sv
// ----------------------------------------------------------------------------
// instr_loader_pkg
// Shared definitions for the instruction-memory program loader.
//   loader_state_t  : session state encoding used by instr_mem_loader
//   DEPTH_DEFAULT   : default instruction memory depth in 32-bit words
//   WORD_BYTES      : bytes per instruction word
//   count_is_legal  : true when a requested word count fits the memory
// ----------------------------------------------------------------------------
package instr_loader_pkg;

   localparam int DEPTH_DEFAULT = 64;
   localparam int WORD_BYTES    = 4;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      BYTES,
      WRITE,
      CHECK,
      DONE
   } loader_state_t;

   // A session must write at least one word and must not run past the end
   // of the memory, so the count byte is only accepted in 1..depth.
   function automatic logic count_is_legal(input logic [7:0] n, input int depth);
      return (n != 8'd0) && (int'(n) <= depth);
   endfunction

endpackage

// File: rtl/loader_word_asm.sv
// ----------------------------------------------------------------------------
// loader_word_asm
// Assembles four stream bytes into one little-endian 32-bit word. The first
// byte of each word lands in bits [7:0], the fourth in bits [31:24].
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   clear      in   restart assembly at byte 0 and zero the word
//   load       in   byte_in is accepted this cycle
//   byte_in    in   stream byte
//   word       out  assembled word (holds its value between words)
//   word_full  out  the byte being loaded this cycle completes a word
// ----------------------------------------------------------------------------
module loader_word_asm
   import instr_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        load,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0] byte_idx;

   // Each accepted byte is inserted at its lane. All four lanes are
   // overwritten for every word, so no clear is needed between words. The
   // index wraps naturally from 3 back to 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byte_idx <= 2'd0;
         word     <= 32'd0;
      end else if (clear) begin
         byte_idx <= 2'd0;
         word     <= 32'd0;
      end else if (load) begin
         word[{byte_idx, 3'b000} +: 8] <= byte_in;
         byte_idx                      <= byte_idx + 2'd1;
      end
   end

   assign word_full = load && (byte_idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// ----------------------------------------------------------------------------
// instr_mem_loader
// Program-load master for the instruction memory. A byte stream arrives over
// a valid/ready handshake: the first byte is the word count N, followed by
// 4*N payload bytes (least significant byte first per word). Each completed
// word is written to memory with a one-cycle wr_en strobe at consecutive
// word addresses starting at ADDR_BASE. The CPU is held while loading.
//
// Optional feature (macro LOADER_CHECKSUM_EN): after the last word, one
// extra byte is accepted and compared with the XOR of all payload bytes; a
// mismatch raises err. Without the macro the session ends after the last
// write.
//
// Parameters:
//   DEPTH      memory depth in words (largest legal N, at most 255)
//   ADDR_BASE  byte address of the first word (word aligned)
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   load_start  in   starts a session (honoured only when idle or done)
//   in_data     in   stream byte
//   in_valid    in   in_data is valid
//   in_ready    out  loader accepts a byte this cycle
//   wr_addr     out  memory byte address
//   wr_data     out  assembled instruction word
//   wr_en       out  memory write strobe, one cycle per word
//   cpu_hold    out  CPU must stall while a session is in progress
//   busy        out  a session is in progress
//   done        out  session finished (sticky until next load_start)
//   err         out  bad count or checksum mismatch (sticky)
// ----------------------------------------------------------------------------
module instr_mem_loader
   import instr_loader_pkg::*;
#(
   parameter int          DEPTH     = DEPTH_DEFAULT,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load_start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        wr_en,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err
);

   loader_state_t state;
   loader_state_t next_state;

   logic [7:0] word_total;
   logic [7:0] word_cnt;
   logic       xfer;
   logic       start_accept;
   logic       last_word;
   logic       byte_load;
   logic       word_full;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum;
`endif

   assign xfer         = in_valid && in_ready;
   assign start_accept = load_start && ((state == IDLE) || (state == DONE));
   assign last_word    = (word_cnt + 8'd1) == word_total;
   assign byte_load    = (state == BYTES) && xfer;

   // Byte-to-word assembly; restarted at the beginning of every session so
   // a fresh load never inherits a partial word.
   loader_word_asm u_word_asm (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (start_accept),
      .load      (byte_load),
      .byte_in   (in_data),
      .word      (wr_data),
      .word_full (word_full)
   );

   // State register. An asynchronous reset returns straight to IDLE, which
   // also drops every state-derived output in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake decode. Only COUNT, BYTES and CHECK consume
   // stream bytes; WRITE deliberately drops in_ready so the word being
   // written cannot be disturbed while the strobe is high.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      wr_en      = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (load_start) begin
               next_state = COUNT;
            end
         end
         COUNT: begin
            in_ready = 1'b1;
            if (xfer) begin
               if (count_is_legal(in_data, DEPTH)) begin
                  next_state = BYTES;
               end else begin
                  next_state = DONE;
               end
            end
         end
         BYTES: begin
            in_ready = 1'b1;
            if (word_full) begin
               next_state = WRITE;
            end
         end
         WRITE: begin
            wr_en = 1'b1;
            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
               next_state = CHECK;
`else
               next_state = DONE;
`endif
            end else begin
               next_state = BYTES;
            end
         end
         CHECK: begin
`ifdef LOADER_CHECKSUM_EN
            in_ready = 1'b1;
            if (xfer) begin
               next_state = DONE;
            end
`else
            next_state = DONE;
`endif
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign busy     = (state != IDLE) && (state != DONE);
   assign cpu_hold = busy;
   assign done     = (state == DONE);

   // Session bookkeeping: word count, write address and sticky error.
   // The address only advances when another word follows, so after the
   // final write it still points at the last word written and can never
   // step past the end of the memory.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_total <= 8'd0;
         word_cnt   <= 8'd0;
         wr_addr    <= ADDR_BASE;
         err        <= 1'b0;
      end else begin
         if (start_accept) begin
            word_cnt <= 8'd0;
            wr_addr  <= ADDR_BASE;
            err      <= 1'b0;
         end
         if ((state == COUNT) && xfer) begin
            word_total <= in_data;
            if (!count_is_legal(in_data, DEPTH)) begin
               err <= 1'b1;
            end
         end
         if (state == WRITE) begin
            word_cnt <= word_cnt + 8'd1;
            if (!last_word) begin
               wr_addr <= wr_addr + 32'(WORD_BYTES);
            end
         end
`ifdef LOADER_CHECKSUM_EN
         if ((state == CHECK) && xfer && (in_data != csum)) begin
            err <= 1'b1;
         end
`endif
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Running XOR over payload bytes only; the count byte is not included.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         csum <= 8'd0;
      end else if (start_accept) begin
         csum <= 8'd0;
      end else if (byte_load) begin
         csum <= csum ^ in_data;
      end
   end
`endif

endmodule
